// File: rtl/ctrl_unit_pipe_pkg.sv
// Shared encodings, control-word types and the instruction decode table
// for the pipelined ID-stage control unit.
package ctrl_unit_pipe_pkg;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_MUL = 2'b11;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_EOR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SBC  = 4'b0110;
    localparam logic [3:0] OP_TST  = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_ORR  = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_MVN  = 4'b1111;
    localparam logic [3:0] OP_LDST = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0000;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic       b;
        logic       s;
        logic [3:0] cmd;
        logic       wb;
        logic       mr;
        logic       mw;
    } ctrl_word_t;

    typedef struct packed {
        ctrl_word_t cw;
        logic       illegal;
        logic       is_mul;
    } decode_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_e;

    function automatic decode_t decode(input logic [1:0] mode, input logic [3:0] opcode,
                                       input logic s);
        decode_t d;
        d = '0;
        case (mode)
            MODE_ALU: begin
                d.cw.wb = 1'b1;
                d.cw.s  = s;
                case (opcode)
                    OP_MOV:  d.cw.cmd = CMD_MOV;
                    OP_MVN:  d.cw.cmd = CMD_MVN;
                    OP_ADD:  d.cw.cmd = CMD_ADD;
                    OP_ADC:  d.cw.cmd = CMD_ADC;
                    OP_SUB:  d.cw.cmd = CMD_SUB;
                    OP_SBC:  d.cw.cmd = CMD_SBC;
                    OP_AND:  d.cw.cmd = CMD_AND;
                    OP_ORR:  d.cw.cmd = CMD_ORR;
                    OP_EOR:  d.cw.cmd = CMD_EOR;
                    OP_CMP: begin
                        d.cw.cmd = CMD_SUB;
                        d.cw.s   = 1'b1;
                        d.cw.wb  = 1'b0;
                    end
                    OP_TST: begin
                        d.cw.cmd = CMD_AND;
                        d.cw.s   = 1'b1;
                        d.cw.wb  = 1'b0;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            MODE_MEM: begin
                if (opcode == OP_LDST) begin
                    d.cw.cmd = CMD_ADD;
                    d.cw.wb  = s;
                    d.cw.mr  = s;
                    d.cw.mw  = ~s;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            MODE_BR: d.cw.b = 1'b1;
            MODE_MUL: begin
                if (opcode == OP_MUL) begin
                    d.cw.cmd = CMD_MUL;
                    d.cw.wb  = 1'b1;
                    d.cw.s   = s;
                    d.is_mul = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        // An undefined encoding must never leak partial control bits
        d.cw = d.illegal ? ctrl_word_t'('0) : d.cw;
        return d;
    endfunction

endpackage

// File: rtl/ctrl_unit_pipe_if.sv
// Decode request / ID-EX control-word bundle between the issuing logic and the control unit.
interface ctrl_unit_pipe_if #(
    parameter int CMD_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [3:0]       opcode;
    logic             s;
    logic [3:0]       cond;
    logic [3:0]       nzcv;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic             b_out;
    logic             s_out;
    logic [CMD_W-1:0] exe_cmd;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             ex_last;
    logic             illegal;
    logic [CNT_W-1:0] squash_cnt;

    modport master (
        output in_valid, mode, opcode, s, cond, nzcv, stall, flush,
        input  in_ready, out_valid, b_out, s_out, exe_cmd, wb_en, mem_r_en, mem_w_en,
               ex_last, illegal, squash_cnt
    );

    modport slave (
        input  in_valid, mode, opcode, s, cond, nzcv, stall, flush,
        output in_ready, out_valid, b_out, s_out, exe_cmd, wb_en, mem_r_en, mem_w_en,
               ex_last, illegal, squash_cnt
    );
endinterface

// File: rtl/ctrl_unit_pipe_cond_check.sv
// Combinational ARM-style condition evaluation against the {N,Z,C,V} flags.
module ctrl_unit_pipe_cond_check
    import ctrl_unit_pipe_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = nzcv;

    // Select the flag predicate named by the condition field
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/ctrl_unit_pipe.sv
// ID-stage control decoder with condition gating, registered ID/EX output stage
// (valid/ready, stall, flush) and multi-cycle MUL sequencing.
module ctrl_unit_pipe
    import ctrl_unit_pipe_pkg::*;
#(
    parameter int CMD_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_unit_pipe_if.slave  bus
);
    localparam int              MCW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [MCW-1:0]  MUL_LOAD  = MCW'(MUL_CYCLES - 1);
    localparam bit              MUL_MULTI = (MUL_CYCLES > 1);

    state_e           state_q, state_d;
    logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
    logic             out_valid_q, out_valid_d;
    ctrl_word_t       cw_q, cw_d;
    logic             illegal_q, illegal_d;
    logic             ex_last_q, ex_last_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    decode_t dec_s;
    logic    pass_s, in_ready_s, accept_s, squash_s, mul_start_s, mul_busy_s;

    ctrl_unit_pipe_cond_check u_cond_check (
        .cond (bus.cond),
        .nzcv (bus.nzcv),
        .pass (pass_s)
    );

    // mul_cnt counts EXE cycles still to follow the current one; at zero the
    // MUL is in its final cycle and the next instruction may be accepted.
    always_comb begin
        dec_s       = decode(bus.mode, bus.opcode, bus.s);
        mul_busy_s  = (state_q == ST_MUL) && (mul_cnt_q != MCW'(0));
        in_ready_s  = rst_n & ~bus.stall &
                      ((state_q == ST_RUN) | ((state_q == ST_MUL) & (mul_cnt_q == MCW'(0))));
        accept_s    = bus.in_valid & in_ready_s;
        squash_s    = accept_s & (dec_s.illegal | ~pass_s);
        mul_start_s = accept_s & ~squash_s & dec_s.is_mul & MUL_MULTI;
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            mul_cnt_q    <= MCW'(0);
            out_valid_q  <= 1'b0;
            cw_q         <= '0;
            illegal_q    <= 1'b0;
            ex_last_q    <= 1'b0;
            squash_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            mul_cnt_q    <= mul_cnt_d;
            out_valid_q  <= out_valid_d;
            cw_q         <= cw_d;
            illegal_q    <= illegal_d;
            ex_last_q    <= ex_last_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    // Next-state: RUN/MUL sequencing
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        if (bus.flush) begin
            state_d   = ST_RUN;
            mul_cnt_d = MCW'(0);
        end else if (bus.stall) begin
            state_d   = state_q;
            mul_cnt_d = mul_cnt_q;
        end else if (mul_busy_s) begin
            mul_cnt_d = mul_cnt_q - MCW'(1);
        end else if (mul_start_s) begin
            state_d   = ST_MUL;
            mul_cnt_d = MUL_LOAD;
        end else begin
            state_d   = ST_RUN;
            mul_cnt_d = MCW'(0);
        end
    end

    // Output-stage next values and squash accounting
    always_comb begin
        out_valid_d  = out_valid_q;
        cw_d         = cw_q;
        illegal_d    = illegal_q;
        ex_last_d    = ex_last_q;
        squash_cnt_d = squash_cnt_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            cw_d        = '0;
            illegal_d   = 1'b0;
            ex_last_d   = 1'b0;
        end else if (bus.stall) begin
            out_valid_d = out_valid_q;
        end else if (mul_busy_s) begin
            ex_last_d = (mul_cnt_q == MCW'(1));
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            illegal_d   = dec_s.illegal;
            if (squash_s) begin
                cw_d         = '0;
                ex_last_d    = 1'b1;
                squash_cnt_d = (&squash_cnt_q) ? squash_cnt_q : squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cw_d      = dec_s.cw;
                ex_last_d = ~mul_start_s;
            end
        end else begin
            out_valid_d = 1'b0;
            cw_d        = '0;
            illegal_d   = 1'b0;
            ex_last_d   = 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.b_out      = cw_q.b;
    assign bus.s_out      = cw_q.s;
    assign bus.exe_cmd    = CMD_W'(cw_q.cmd);
    assign bus.wb_en      = cw_q.wb;
    assign bus.mem_r_en   = cw_q.mr;
    assign bus.mem_w_en   = cw_q.mw;
    assign bus.ex_last    = ex_last_q;
    assign bus.illegal    = illegal_q;
    assign bus.squash_cnt = squash_cnt_q;
endmodule
